// File: rtl/pipe_hold_ctrl.sv
// Central pipeline hold-vector generator: fetch/data bus trackers,
// mul/div latency timer, single-cycle load-use stall, stall counter.
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   i_req_valid, i_resp        - fetch request and instruction bus data_ok
//   i_issue                    - gated fetch request to the instruction bus
//   d_req_valid, d_resp        - memory request and data bus data_ok
//   d_issue                    - gated data request to the data bus
//   md_start, md_done          - mul/div start and result-valid level
//   lu_hazard                  - load-use dependency seen in decode
//   hold_vec, advance          - hold vector (nonzero = hold); advance = all zero
//   stall_cycles               - saturating count of held cycles
module pipe_hold_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req_valid,
  input  logic             i_resp,
  output logic             i_issue,
  input  logic             d_req_valid,
  input  logic             d_resp,
  output logic             d_issue,
  input  logic             md_start,
  output logic             md_done,
  input  logic             lu_hazard,
  output logic [6:0]       hold_vec,
  output logic             advance,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    B_IDLE,
    B_BUSY,
    B_DONE
  } bus_st_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_RUN,
    M_DONE
  } md_st_e;

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  bus_st_e          if_q, if_d;
  bus_st_e          dm_q, dm_d;
  md_st_e           md_q, md_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             lu_served_q, lu_served_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             i_busy;
  logic             d_busy;
  logic             md_busy;
  logic             lu_stall;

  function automatic logic bus_busy(
    input bus_st_e st,
    input logic    req,
    input logic    resp
  );
    logic b;
    b = 1'b0;
    unique case (st)
      B_IDLE:  b = req & ~resp;
      B_BUSY:  b = ~resp;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Busy bits never look at advance, so advance feeding the
  // next-state logic below forms no combinational loop.
  function automatic bus_st_e bus_next(
    input bus_st_e st,
    input logic    req,
    input logic    resp,
    input logic    adv
  );
    bus_st_e n;
    n = st;
    unique case (st)
      B_IDLE: begin
        if (req & ~resp)
          n = B_BUSY;
        else if (req & resp & ~adv)
          n = B_DONE;
      end
      B_BUSY: begin
        if (resp)
          n = adv ? B_IDLE : B_DONE;
      end
      B_DONE: begin
        if (adv)
          n = B_IDLE;
      end
      default: n = B_IDLE;
    endcase
    return n;
  endfunction

  always_comb begin
    i_busy   = bus_busy(if_q, i_req_valid, i_resp);
    d_busy   = bus_busy(dm_q, d_req_valid, d_resp);
    md_busy  = (md_q == M_RUN) |
               ((md_q == M_IDLE) & md_start);
    lu_stall = lu_hazard & ~lu_served_q;
    hold_vec = {3'b000, lu_stall, md_busy, d_busy, i_busy};
    advance  = ~|hold_vec;
    i_issue  = i_req_valid & (if_q != B_DONE);
    d_issue  = d_req_valid & (dm_q != B_DONE);
    md_done  = (md_q == M_DONE);
  end

  always_comb begin
    if_d = bus_next(if_q, i_req_valid, i_resp, advance);
    dm_d = bus_next(dm_q, d_req_valid, d_resp, advance);

    md_d  = md_q;
    cnt_d = cnt_q;
    unique case (md_q)
      M_IDLE: begin
        if (md_start) begin
          cnt_d = MD_LOAD;
          md_d  = M_RUN;
        end
      end
      M_RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1)
          md_d = M_DONE;
      end
      M_DONE: begin
        if (advance)
          md_d = M_IDLE;
      end
      default: md_d = M_IDLE;
    endcase

    // A hazard still asserted across the advance that follows its
    // stall is the same dependency; re-arm only once it drops.
    lu_served_d = lu_served_q;
    if (lu_stall)
      lu_served_d = 1'b1;
    else if (advance & ~lu_hazard)
      lu_served_d = 1'b0;

    stall_d = stall_q;
    if ((|hold_vec) && !(&stall_q))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q        <= B_IDLE;
      dm_q        <= B_IDLE;
      md_q        <= M_IDLE;
      cnt_q       <= 8'd0;
      lu_served_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      if_q        <= if_d;
      dm_q        <= dm_d;
      md_q        <= md_d;
      cnt_q       <= cnt_d;
      lu_served_q <= lu_served_d;
      stall_q     <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Testbench for pipe_hold_ctrl: per-cycle vector table with
// expected hold/handshake outputs and stall counter checkpoints.
module tb_pipe_hold_ctrl;

  logic        clk;
  logic        reset;
  logic        i_req_valid;
  logic        i_resp;
  logic        d_req_valid;
  logic        d_resp;
  logic        md_start;
  logic        lu_hazard;

  logic        i_issue, d_issue, md_done, advance;
  logic [6:0]  hold_vec;
  logic [31:0] stall_cycles;

  logic        s_i_issue, s_d_issue, s_md_done, s_advance;
  logic [6:0]  s_hold_vec;
  logic [3:0]  s_stall_cycles;

  int ncmp;
  int nbad;

  pipe_hold_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_resp       (i_resp),
    .i_issue      (i_issue),
    .d_req_valid  (d_req_valid),
    .d_resp       (d_resp),
    .d_issue      (d_issue),
    .md_start     (md_start),
    .md_done      (md_done),
    .lu_hazard    (lu_hazard),
    .hold_vec     (hold_vec),
    .advance      (advance),
    .stall_cycles (stall_cycles)
  );

  pipe_hold_ctrl #(.MD_CYCLES(8), .CNT_W(4)) u_sat (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_resp       (i_resp),
    .i_issue      (s_i_issue),
    .d_req_valid  (d_req_valid),
    .d_resp       (d_resp),
    .d_issue      (s_d_issue),
    .md_start     (md_start),
    .md_done      (s_md_done),
    .lu_hazard    (lu_hazard),
    .hold_vec     (s_hold_vec),
    .advance      (s_advance),
    .stall_cycles (s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {reset, i_req, i_resp, d_req, d_resp, md_start, lu_hazard}
  // o  = {advance, i_issue, d_issue, md_done}
  // cnt = expected stall count at this cycle, -1 = not checked
  typedef struct {
    logic [6:0] in;
    logic [3:0] h;
    logic [3:0] o;
    int         cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [6:0] in, logic [3:0] h,
                              logic [3:0] o, int cnt);
    vec_t v;
    v.in  = in;
    v.h   = h;
    v.o   = o;
    v.cnt = cnt;
    return v;
  endfunction

  initial begin
    vec_t t;
    logic [3:0] go, so;
    logic [6:0] eh;
    int esat;

    ncmp = 0;
    nbad = 0;

    // idle after reset
    tv.push_back(mk(7'b0000000, 4'b0000, 4'b1000, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(7'b0000000, 4'b0000, 4'b1000, -1));
    // fetch, response after 3 waiting cycles
    tv.push_back(mk(7'b0100000, 4'b0001, 4'b0100, 0));
    tv.push_back(mk(7'b0100000, 4'b0001, 4'b0100, -1));
    tv.push_back(mk(7'b0100000, 4'b0001, 4'b0100, -1));
    tv.push_back(mk(7'b0110000, 4'b0000, 4'b1100, -1));
    tv.push_back(mk(7'b0000000, 4'b0000, 4'b1000, -1));
    // fetch done first, parks while data waits
    tv.push_back(mk(7'b0101000, 4'b0011, 4'b0110, 3));
    tv.push_back(mk(7'b0111000, 4'b0010, 4'b0110, -1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(7'b0101000, 4'b0010, 4'b0010, -1));
    tv.push_back(mk(7'b0101100, 4'b0000, 4'b1010, -1));
    tv.push_back(mk(7'b0100000, 4'b0001, 4'b0100, -1));
    tv.push_back(mk(7'b0110000, 4'b0000, 4'b1100, -1));
    // mul/div pulse
    tv.push_back(mk(7'b0000010, 4'b0100, 4'b0000, 9));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(7'b0000000, 4'b0100, 4'b0000, -1));
    tv.push_back(mk(7'b0000000, 4'b0000, 4'b1001, -1));
    // mul/div with md_start held throughout
    tv.push_back(mk(7'b0000010, 4'b0100, 4'b0000, 17));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(7'b0000010, 4'b0100, 4'b0000, -1));
    tv.push_back(mk(7'b0000010, 4'b0000, 4'b1001, -1));
    tv.push_back(mk(7'b0000000, 4'b0000, 4'b1000, -1));
    // load-use held 3 cycles, then a second hazard
    tv.push_back(mk(7'b0000001, 4'b1000, 4'b0000, 25));
    tv.push_back(mk(7'b0000001, 4'b0000, 4'b1000, -1));
    tv.push_back(mk(7'b0000001, 4'b0000, 4'b1000, -1));
    tv.push_back(mk(7'b0000000, 4'b0000, 4'b1000, -1));
    tv.push_back(mk(7'b0000001, 4'b1000, 4'b0000, -1));
    tv.push_back(mk(7'b0000001, 4'b0000, 4'b1000, -1));
    tv.push_back(mk(7'b0000000, 4'b0000, 4'b1000, -1));
    // same-cycle fetch response while stalled -> DONE, stray resp
    tv.push_back(mk(7'b0110001, 4'b1000, 4'b0100, 27));
    tv.push_back(mk(7'b0100000, 4'b0000, 4'b1000, -1));
    tv.push_back(mk(7'b0110000, 4'b0000, 4'b1100, -1));
    tv.push_back(mk(7'b0010000, 4'b0000, 4'b1000, -1));
    // reset mid-operation, then a stray data response
    tv.push_back(mk(7'b0001010, 4'b0110, 4'b0010, 28));
    tv.push_back(mk(7'b0001000, 4'b0110, 4'b0010, -1));
    tv.push_back(mk(7'b1000000, 4'b0110, 4'b0000, -1));
    tv.push_back(mk(7'b0000100, 4'b0000, 4'b1000, 0));
    tv.push_back(mk(7'b0000000, 4'b0000, 4'b1000, 0));

    reset       = 1'b1;
    i_req_valid = 1'b0;
    i_resp      = 1'b0;
    d_req_valid = 1'b0;
    d_resp      = 1'b0;
    md_start    = 1'b0;
    lu_hazard   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      t = tv[i];
      {reset, i_req_valid, i_resp, d_req_valid,
       d_resp, md_start, lu_hazard} = t.in;
      @(negedge clk);
      eh = {3'b000, t.h};
      go = {advance, i_issue, d_issue, md_done};
      so = {s_advance, s_i_issue, s_d_issue, s_md_done};
      ncmp++;
      if (hold_vec !== eh || go !== t.o ||
          s_hold_vec !== eh || so !== t.o) begin
        nbad++;
        $display("FAIL vec%0d: hold=%b/%b outs=%b/%b required hold=%b outs=%b",
                 i, hold_vec, s_hold_vec, go, so, eh, t.o);
      end
      if (t.cnt >= 0) begin
        esat = (t.cnt > 15) ? 15 : t.cnt;
        ncmp++;
        if (stall_cycles !== 32'(t.cnt) ||
            s_stall_cycles !== 4'(esat)) begin
          nbad++;
          $display("FAIL cnt%0d: stall=%0d sat=%0d required %0d/%0d",
                   i, stall_cycles, s_stall_cycles, t.cnt, esat);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
